// File: rtl/next_piece_preview_ctrl.sv
// Next-piece preview sequencer: frame-synchronous piece commit, enable FSM and a
// two-stage pixel pipeline that addresses the tetromino sprite ROM.
module next_piece_preview_ctrl #(
    parameter int WIN_X      = 480,
    parameter int WIN_Y      = 64,
    parameter int SCALE_LOG2 = 2,
    parameter int COLOR_W    = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [9:0]         pixel_row,
    input  logic [9:0]         pixel_column,
    input  logic               vsync_start,
    input  logic               enable_in,
    input  logic               next_block_wr,
    input  logic [2:0]         next_block_in,
    output logic [2:0]         sprite_block,
    output logic [2:0]         sprite_row,
    input  logic [7:0]         sprite_pixels,
    output logic               preview_on,
    output logic [COLOR_W-1:0] preview_color,
    output logic [2:0]         shown_block
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [10:0] WIN_SIZE = 11'(8 << SCALE_LOG2);

    state_t     state;
    logic [2:0] pending_block;
    logic       pending_valid;
    logic       drawing;

    logic [10:0] dx_p0;
    logic [10:0] dy_p0;
    logic        vld_p0;
    logic        vld_p1;
    logic [2:0]  bit_idx_p1;

    function automatic logic [COLOR_W-1:0] palette(input logic [2:0] code);
        logic [11:0] rgb;
        case (code)
            3'd0:    rgb = 12'h0FF;
            3'd1:    rgb = 12'hF80;
            3'd2:    rgb = 12'h00F;
            3'd3:    rgb = 12'hFF0;
            3'd4:    rgb = 12'h0F0;
            3'd5:    rgb = 12'hA0F;
            3'd6:    rgb = 12'hF00;
            default: rgb = 12'h000;
        endcase
        return COLOR_W'(rgb);
    endfunction

    // Pending register is only ever copied to shown_block during vertical blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_block <= 3'd0;
            pending_valid <= 1'b0;
            shown_block   <= 3'd0;
        end else begin
            if (vsync_start && pending_valid) begin
                shown_block   <= pending_block;
                pending_valid <= 1'b0;
            end
            if (next_block_wr && next_block_in != 3'd7) begin
                pending_block <= next_block_in;
                pending_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    if (enable_in) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!enable_in)       state <= ST_OFF;
                    else if (vsync_start) state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!enable_in) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (enable_in)        state <= ST_ACTIVE;
                    else if (vsync_start) state <= ST_OFF;
                end
                default: state <= ST_OFF;
            endcase
        end
    end

    assign drawing = (state == ST_ACTIVE) || (state == ST_DRAIN);

    // Stage 0 -> 1: window test with wrapping subtraction, ROM address generation.
    assign dx_p0  = {1'b0, pixel_column} - 11'(WIN_X);
    assign dy_p0  = {1'b0, pixel_row} - 11'(WIN_Y);
    assign vld_p0 = video_on && drawing && (dx_p0 < WIN_SIZE) && (dy_p0 < WIN_SIZE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            bit_idx_p1   <= 3'd0;
            sprite_row   <= 3'd0;
            sprite_block <= 3'd0;
        end else begin
            vld_p1       <= vld_p0;
            bit_idx_p1   <= 3'd7 - dx_p0[SCALE_LOG2 +: 3];
            sprite_row   <= dy_p0[SCALE_LOG2 +: 3];
            sprite_block <= shown_block;
        end
    end

    // Stage 1 -> 2: select the ROM bit and colour it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preview_on    <= 1'b0;
            preview_color <= '0;
        end else begin
            preview_on    <= vld_p1 && sprite_pixels[bit_idx_p1];
            preview_color <= (vld_p1 && sprite_pixels[bit_idx_p1]) ? palette(sprite_block) : '0;
        end
    end

endmodule

// File: tb/tb_next_piece_preview_ctrl.sv
// Scoreboard bench for next_piece_preview_ctrl: directed scenarios plus random scanning
// compared against a frame-level behavioural model and a bench-side sprite ROM.
module tb_next_piece_preview_ctrl;
    localparam int WIN_X = 480;
    localparam int WIN_Y = 64;
    localparam int SCALE_LOG2 = 2;
    localparam int COLOR_W = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_row = '0;
    logic [9:0]  pixel_column = '0;
    logic        vsync_start = 1'b0;
    logic        enable_in = 1'b0;
    logic        next_block_wr = 1'b0;
    logic [2:0]  next_block_in = '0;
    logic [2:0]  sprite_block;
    logic [2:0]  sprite_row;
    logic [7:0]  sprite_pixels;
    logic        preview_on;
    logic [COLOR_W-1:0] preview_color;
    logic [2:0]  shown_block;

    next_piece_preview_ctrl #(
        .WIN_X(WIN_X), .WIN_Y(WIN_Y), .SCALE_LOG2(SCALE_LOG2), .COLOR_W(COLOR_W)
    ) dut (
        .clk(clk), .reset(reset), .video_on(video_on), .pixel_row(pixel_row),
        .pixel_column(pixel_column), .vsync_start(vsync_start), .enable_in(enable_in),
        .next_block_wr(next_block_wr), .next_block_in(next_block_in),
        .sprite_block(sprite_block), .sprite_row(sprite_row), .sprite_pixels(sprite_pixels),
        .preview_on(preview_on), .preview_color(preview_color), .shown_block(shown_block)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom [8][8];
    logic [11:0] pal [8];
    assign sprite_pixels = rom[sprite_block][sprite_row];

    typedef struct {
        logic        on;
        logic [11:0] color;
        logic [2:0]  blk;
    } exp_t;
    exp_t q[$];

    int errors = 0;
    int checks = 0;
    int lit_cnt = 0;
    logic [11:0] lit_col = '0;

    // Model: whether the preview is drawing, requested-but-waiting, or idle.
    localparam int M_IDLE = 0, M_ARMED = 1, M_SHOW = 2, M_FINISH = 3;
    int         m_mode;
    logic [2:0] m_pend, m_shown;
    logic       m_pend_v;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic model_pixel();
        int dx, dy, sz, cell_x, cell_y;
        logic [7:0] bits;
        dx = int'(pixel_column) - WIN_X;
        dy = int'(pixel_row) - WIN_Y;
        sz = 8 * (1 << SCALE_LOG2);
        if (!video_on || !(m_mode == M_SHOW || m_mode == M_FINISH)) return 1'b0;
        if (dx < 0 || dy < 0 || dx >= sz || dy >= sz) return 1'b0;
        cell_x = dx / (1 << SCALE_LOG2);
        cell_y = dy / (1 << SCALE_LOG2);
        bits = rom[m_shown][cell_y];
        return bits[7 - cell_x];
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pend = 3'd0;
        m_shown = 3'd0;
        m_pend_v = 1'b0;
    endtask

    // Called at a negedge with inputs set; predicts and advances one clock.
    task automatic cycle();
        exp_t e;
        e.on = model_pixel();
        e.color = e.on ? pal[m_shown] : 12'h000;
        if (vsync_start && m_pend_v) begin
            m_shown = m_pend;
            m_pend_v = 1'b0;
        end
        if (next_block_wr && next_block_in != 3'd7) begin
            m_pend = next_block_in;
            m_pend_v = 1'b1;
        end
        if (m_mode == M_IDLE) begin
            if (enable_in) m_mode = M_ARMED;
        end else if (m_mode == M_ARMED) begin
            if (!enable_in) m_mode = M_IDLE;
            else if (vsync_start) m_mode = M_SHOW;
        end else if (m_mode == M_SHOW) begin
            if (!enable_in) m_mode = M_FINISH;
        end else begin
            if (enable_in) m_mode = M_SHOW;
            else if (vsync_start) m_mode = M_IDLE;
        end
        e.blk = m_shown;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        next_block_wr = 1'b0;
        vsync_start = 1'b0;
    endtask

    task automatic write_code(input int code);
        next_block_in = 3'(code);
        next_block_wr = 1'b1;
        cycle();
    endtask

    task automatic vsync();
        vsync_start = 1'b1;
        cycle();
    endtask

    task automatic scan(input int row, input int c0, input int c1, input logic vo);
        lit_cnt = 0;
        for (int c = c0; c <= c1; c++) begin
            pixel_row = 10'(row);
            pixel_column = 10'(c);
            video_on = vo;
            cycle();
        end
        video_on = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_preview_on"}, int'(preview_on), 0);
        chk({tag, "_preview_color"}, int'(preview_color), 0);
        chk({tag, "_sprite_block"}, int'(sprite_block), 0);
        chk({tag, "_sprite_row"}, int'(sprite_row), 0);
        chk({tag, "_shown_block"}, int'(shown_block), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one scoreboard entry per clock, output lags the input by two edges.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && q.size() >= 2) begin
                e = q.pop_front();
                chk("preview_on", int'(preview_on), int'(e.on));
                chk("preview_color", int'(preview_color), int'(e.color));
                chk("sprite_block", int'(sprite_block), int'(e.blk));
                if (preview_on) begin
                    lit_cnt++;
                    lit_col = preview_color;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        for (int b = 0; b < 8; b++)
            for (int r = 0; r < 8; r++) rom[b][r] = 8'h00;
        rom[0][3] = 8'hFF; rom[0][4] = 8'hFF;
        rom[1][1] = 8'h30; rom[1][2] = 8'h30; rom[1][3] = 8'h30; rom[1][4] = 8'h3C;
        rom[2][1] = 8'h0C; rom[2][2] = 8'h0C; rom[2][3] = 8'h0C; rom[2][4] = 8'h3C;
        rom[3][2] = 8'h3C; rom[3][3] = 8'h3C; rom[3][4] = 8'h3C; rom[3][5] = 8'h3C;
        rom[4][3] = 8'h1E; rom[4][4] = 8'h78;
        rom[5][2] = 8'h7E; rom[5][3] = 8'h18; rom[5][4] = 8'h18;
        rom[6][3] = 8'h78; rom[6][4] = 8'h1E;
        pal[0] = 12'h0FF; pal[1] = 12'hF80; pal[2] = 12'h00F; pal[3] = 12'hFF0;
        pal[4] = 12'h0F0; pal[5] = 12'hA0F; pal[6] = 12'hF00; pal[7] = 12'h000;
        model_reset();

        #12;
        check_outputs_zero("reset");
        do_reset();

        // O piece committed at the first frame boundary.
        enable_in = 1'b1;
        cycle();
        write_code(3);
        vsync();
        chk("t1_shown", int'(shown_block), 3);
        scan(76, 480, 511, 1'b1);
        chk("t1_lit_count", lit_cnt, 16);
        chk("t1_lit_color", int'(lit_col), 12'hFF0);

        // Mid-frame write does not disturb the frame in progress.
        write_code(0);
        scan(76, 480, 511, 1'b1);
        chk("t2_still_O", lit_cnt, 16);
        chk("t2_shown_before", int'(shown_block), 3);
        vsync();
        chk("t2_shown_after", int'(shown_block), 0);
        scan(80, 480, 511, 1'b1);
        chk("t2_I_row4", lit_cnt, 32);
        chk("t2_I_color", int'(lit_col), 12'h0FF);

        // Last write wins; code 7 is ignored.
        write_code(5);
        write_code(6);
        vsync();
        chk("t3_last_wins", int'(shown_block), 6);
        write_code(7);
        vsync();
        chk("t3_code7_ignored", int'(shown_block), 6);

        // Write coinciding with vsync: old pending commits, new one waits a frame.
        write_code(4);
        next_block_in = 3'd2;
        next_block_wr = 1'b1;
        vsync_start = 1'b1;
        cycle();
        chk("t4_old_commits", int'(shown_block), 4);
        vsync();
        chk("t4_new_next", int'(shown_block), 2);

        // Enable dropped mid-frame: finish the frame, then stop; re-enable waits a frame.
        write_code(0);
        vsync();
        scan(80, 480, 495, 1'b1);
        chk("t5_before_drop", lit_cnt, 16);
        enable_in = 1'b0;
        scan(80, 496, 511, 1'b1);
        chk("t5_drain_draws", lit_cnt, 16);
        vsync();
        scan(80, 480, 511, 1'b1);
        chk("t5_off", lit_cnt, 0);
        enable_in = 1'b1;
        scan(80, 480, 511, 1'b1);
        chk("t5_wait_dark", lit_cnt, 0);
        vsync();
        scan(80, 480, 511, 1'b1);
        chk("t5_active_again", lit_cnt, 32);

        // Window boundaries and blanking.
        scan(80, 479, 512, 1'b1);
        chk("t6_col_edges", lit_cnt, 32);
        scan(63, 480, 511, 1'b1);
        chk("t6_row63", lit_cnt, 0);
        scan(96, 480, 511, 1'b1);
        chk("t6_row96", lit_cnt, 0);
        scan(80, 480, 511, 1'b0);
        chk("t6_video_off", lit_cnt, 0);

        // Asynchronous reset in the middle of a lit scan.
        for (int c = 480; c < 490; c++) begin
            pixel_row = 10'd80;
            pixel_column = 10'(c);
            video_on = 1'b1;
            cycle();
        end
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("midscan_reset");
        q.delete();
        model_reset();
        @(negedge clk);
        video_on = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        scan(80, 480, 511, 1'b1);
        chk("post_reset_dark", lit_cnt, 0);
        vsync();
        scan(80, 480, 511, 1'b1);
        chk("post_reset_active", lit_cnt, 32);

        // Randomised frames around the window.
        for (int n = 0; n < 3000; n++) begin
            pixel_column = 10'($urandom_range(470, 522));
            pixel_row = 10'($urandom_range(58, 102));
            video_on = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) enable_in = ~enable_in;
            if ($urandom_range(0, 19) == 0) begin
                next_block_wr = 1'b1;
                next_block_in = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 79) == 0) vsync_start = 1'b1;
            cycle();
        end
        video_on = 1'b0;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/next_piece_preview_ctrl.md
Name: next_piece_preview_ctrl

Overview:
Sequences the hard-coded tetromino sprite ROM (3-bit block code, 3-bit row in, 8-bit row bitmap out) for the "next piece" preview window of the VGA display.
- Latches the CPU-supplied next-piece code and commits it only at a frame boundary, so the preview never tears.
- Translates VGA pixel coordinates into ROM row/bit addresses with integer scaling, and produces a pipelined pixel-on flag plus a per-piece colour for the VGA colour mux.
- Sits between the VGA timing generator, the CPU peripheral register file and the sprite ROM.

Parameters:
WIN_X, 480, screen column of the preview window's left edge.
WIN_Y, 64, screen row of the preview window's top edge.
SCALE_LOG2, 2, each sprite pixel is drawn as (1<<SCALE_LOG2) x (1<<SCALE_LOG2) screen pixels; window is (8<<SCALE_LOG2) square. Legal range 0..3.
COLOR_W, 12, width of the colour output (4:4:4 RGB).

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
video_on  in  1  high during the visible area
pixel_row  in  10  current VGA row
pixel_column  in  10  current VGA column
vsync_start  in  1  one-cycle pulse at the first cycle of vertical blank
enable_in  in  1  CPU request: preview visible
next_block_wr  in  1  one-cycle CPU write strobe
next_block_in  in  3  next piece code, 0..6 = I,L,J,O,S,T,Z
sprite_block  out  3  block code to the sprite ROM
sprite_row  out  3  row select to the sprite ROM
sprite_pixels  in  8  ROM row bitmap (combinational ROM); bit 7 = leftmost
preview_on  out  1  current pixel belongs to a lit sprite cell
preview_color  out  COLOR_W  colour for the lit pixel, 0 when preview_on = 0
shown_block  out  3  block code currently displayed (status readback)

Behaviour:
- Reset values: all outputs 0.
  - Internal state: pending_block = 0, pending_valid = 0, shown_block = 0, FSM = OFF, pipeline valid flags = 0.
- Write path:
  - next_block_wr with next_block_in in 0..6 sets pending_block = next_block_in and pending_valid = 1.
  - A code of 7 is ignored entirely; the pending state is unchanged.
  - A later write before vsync_start overwrites the earlier one (last write wins).
- Commit:
  - On vsync_start with pending_valid = 1: shown_block <= pending_block and pending_valid <= 0.
  - If next_block_wr coincides with vsync_start, the old pending value commits. The new value becomes pending, with pending_valid = 1, for the next frame.
- Frame FSM, evaluated every cycle; transitions on enable changes take effect only at vsync_start:
  - OFF: go to WAIT when enable_in = 1.
  - WAIT: go to ACTIVE on vsync_start if enable_in = 1; go back to OFF if enable_in = 0.
  - ACTIVE: go to DRAIN when enable_in = 0.
  - DRAIN: the rest of the frame is still drawn; go to OFF on vsync_start, or back to ACTIVE if enable_in = 1 again before then.
  - Drawing is permitted only in ACTIVE and DRAIN.
- Pipeline, fixed 2-cycle latency from pixel_row/pixel_column to preview_on/preview_color:
  - Stage 1 (registered):
    - in_win = video_on & drawing & (pixel_column - WIN_X) < (8<<SCALE_LOG2) & (pixel_row - WIN_Y) < (8<<SCALE_LOG2).
    - Use 11-bit unsigned subtraction, so coordinates left of or above the window wrap large and fail the compare.
    - sprite_row = dy >> SCALE_LOG2; bit_idx = 7 - (dx >> SCALE_LOG2); sprite_block = shown_block.
  - Stage 2 (registered): preview_on = in_win_q & sprite_pixels[bit_idx_q]; preview_color = palette(sprite_block) when preview_on, else 0.
  - sprite_block and sprite_row are registered outputs, so the ROM sees a stable address for a full cycle.
- Palette:
  - I 0x0FF, L 0xF80, J 0x00F, O 0xFF0, S 0x0F0, T 0xA0F, Z 0xF00.
  - For COLOR_W > 12, zero-extend on the MSB side.
- Because shown_block changes only in vertical blank, the displayed piece never changes mid-frame.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous). After release, the FSM is OFF and nothing is drawn until a full WAIT→ACTIVE sequence completes.

Test Plan:
1. Reset, enable_in = 1, write code 3 (O), pulse vsync_start, scan row 64+12 (sprite row 3), columns 480..511 -> preview_on high exactly for columns 488..503, delayed 2 cycles; colour 0xFF0; shown_block = 3.
2. With O shown, write code 0 (I) mid-frame -> the current frame still shows O. After vsync_start, row 64+16 (sprite row 4) is lit for all 32 columns in colour 0x0FF.
3. Write code 5, then code 6, in the same frame, then vsync_start -> shown_block = 6. Write code 7 -> ignored, shown_block stays 6 after the next vsync_start.
4. Pulse next_block_wr (code 2) on the same cycle as vsync_start while pending = 4 -> shown_block = 4 this frame, 2 after the following vsync_start.
5. Drop enable_in mid-frame -> drawing continues until vsync_start, then preview_on stays 0. Raise enable_in again -> nothing is drawn until the following vsync_start.
6. Coordinates at column 479, column 512, row 63, row 96, and video_on = 0 inside the window -> preview_on = 0. Assert reset mid-scan -> all outputs are 0 in the same cycle.
